// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate arbiter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;
  localparam int   MAX_GATES = 8;

  // Gate-index width; a single-bit index is kept even for degenerate counts.
  function automatic int gate_idx_w(input int num_gates);
    return (num_gates > 1) ? $clog2(num_gates) : 1;
  endfunction

endpackage

// File: rtl/parking_gate_arbiter_picker.sv
// Combinational round-robin picker: first eligible gate at or above ptr, wrapping.
module parking_rr_picker
  import parking_pkg::*;
#(
  parameter int NUM_GATES = 4,
  localparam int IDX_W = gate_idx_w(NUM_GATES)
) (
  input  logic [NUM_GATES-1:0] req,
  input  logic [NUM_GATES-1:0] hold_mask,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  logic [NUM_GATES-1:0] eligible;
  int                   idx;

  assign eligible = req & ~hold_mask;

  // Scanning from the far end lets the closest candidate win without a break.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = NUM_GATES - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_GATES;
      if (eligible[IDX_W'(idx)]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing the occupancy counter between gate controllers.
// Optional vacancy precheck on entries: define PARKING_ARB_PRECHECK_EN.
//
// state | meaning
// IDLE  | pick the next eligible gate, capture its dir/class
// ISSUE | enter/exit event pulse is on the counter inputs
// WAIT  | counter updates; illegal flag sampled at the end of this cycle
// RESP  | ack/grant pulse to the served gate
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int NUM_GATES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] gate_req,
  input  logic [NUM_GATES-1:0] gate_dir,
  input  logic [NUM_GATES-1:0] gate_is_uni,
  output logic [NUM_GATES-1:0] gate_ack,
  output logic [NUM_GATES-1:0] gate_grant,
  output logic                 busy,
  output logic                 car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_entered,
  output logic                 is_uni_car_exited,
  input  logic                 is_vacated_space,
  input  logic                 uni_is_vacated_space,
  input  logic                 illegal_enter,
  input  logic                 illegal_exit
);

  localparam int IDX_W = gate_idx_w(NUM_GATES);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, win_q, win_d, pick_idx;
  logic                 dir_q, dir_d, uni_q, uni_d;
  logic [NUM_GATES-1:0] mask_q, mask_d, ack_d, grant_d, win_onehot, pick_onehot;
  logic                 ent_d, ext_d, uent_d, uext_d;
  logic                 pick_valid, pick_dir, pick_uni, flag, precheck_deny;

  parking_rr_picker #(.NUM_GATES(NUM_GATES)) u_picker (
    .req       (gate_req),
    .hold_mask (mask_q),
    .ptr       (ptr_q),
    .valid     (pick_valid),
    .winner    (pick_idx)
  );

  assign pick_dir    = gate_dir[pick_idx];
  assign pick_uni    = gate_is_uni[pick_idx];
  assign pick_onehot = NUM_GATES'(1) << pick_idx;
  assign win_onehot  = NUM_GATES'(1) << win_q;
  assign flag        = (dir_q == DIR_EXIT) ? illegal_exit : illegal_enter;
  assign busy        = (state_q != IDLE);

`ifdef PARKING_ARB_PRECHECK_EN
  assign precheck_deny = (pick_dir == DIR_ENTER) &&
                         !(pick_uni ? uni_is_vacated_space : is_vacated_space);
`else
  logic unused_vacancy;
  assign unused_vacancy = is_vacated_space ^ uni_is_vacated_space;
  assign precheck_deny  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    dir_d   = dir_q;
    uni_d   = uni_q;
    mask_d  = mask_q;
    ent_d   = 1'b0;
    ext_d   = 1'b0;
    uent_d  = 1'b0;
    uext_d  = 1'b0;
    ack_d   = '0;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (pick_valid) begin
          win_d = pick_idx;
          dir_d = pick_dir;
          uni_d = pick_uni;
          if (precheck_deny) begin
            state_d = RESP;
            ack_d   = pick_onehot;
          end else begin
            state_d = ISSUE;
            ent_d   = (pick_dir == DIR_ENTER);
            ext_d   = (pick_dir == DIR_EXIT);
            uent_d  = (pick_dir == DIR_ENTER) && pick_uni;
            uext_d  = (pick_dir == DIR_EXIT) && pick_uni;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = RESP;
        ack_d   = win_onehot;
        grant_d = flag ? '0 : win_onehot;
      end
      RESP: begin
        state_d = IDLE;
        // The served gate still holds req during the next IDLE cycle.
        mask_d  = win_onehot;
        ptr_d   = (int'(win_q) == NUM_GATES - 1) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      ptr_q              <= '0;
      win_q              <= '0;
      dir_q              <= 1'b0;
      uni_q              <= 1'b0;
      mask_q             <= '0;
      gate_ack           <= '0;
      gate_grant         <= '0;
      car_entered        <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_entered <= 1'b0;
      is_uni_car_exited  <= 1'b0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      win_q              <= win_d;
      dir_q              <= dir_d;
      uni_q              <= uni_d;
      mask_q             <= mask_d;
      gate_ack           <= ack_d;
      gate_grant         <= grant_d;
      car_entered        <= ent_d;
      car_exited         <= ext_d;
      is_uni_car_entered <= uent_d;
      is_uni_car_exited  <= uext_d;
    end
  end

endmodule
